// File: rtl/inv_mix_columns_seq_pkg.sv
// -----------------------------------------------------------------------------
// inv_mix_columns_seq_pkg
// Shared AES helpers for the decryption-side InvMixColumns engine:
//   AES_POLY  : low byte of the reduction polynomial x^8+x^4+x^3+x+1
//   state_e   : engine FSM encoding (IDLE / BUSY / DONE)
//   xtime     : multiply by x in GF(2^8)
//   gf_mul9/0b/0d/0e : InvMixColumns coefficients built from chained xtime
//   inv_rcon  : step a round constant backwards (divide by x in GF(2^8))
// All functions take the polynomial as an argument so a parameterised
// instance can override it.
// -----------------------------------------------------------------------------
package inv_mix_columns_seq_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] v, input logic [7:0] poly);
    return {v[6:0], 1'b0} ^ (v[7] ? poly : 8'h00);
  endfunction

  // 9 = 8 + 1
  function automatic logic [7:0] gf_mul9(input logic [7:0] v, input logic [7:0] poly);
    logic [7:0] x2, x4, x8;
    x2 = xtime(v, poly);
    x4 = xtime(x2, poly);
    x8 = xtime(x4, poly);
    return x8 ^ v;
  endfunction

  // 0b = 8 + 2 + 1
  function automatic logic [7:0] gf_mul0b(input logic [7:0] v, input logic [7:0] poly);
    logic [7:0] x2, x4, x8;
    x2 = xtime(v, poly);
    x4 = xtime(x2, poly);
    x8 = xtime(x4, poly);
    return x8 ^ x2 ^ v;
  endfunction

  // 0d = 8 + 4 + 1
  function automatic logic [7:0] gf_mul0d(input logic [7:0] v, input logic [7:0] poly);
    logic [7:0] x2, x4, x8;
    x2 = xtime(v, poly);
    x4 = xtime(x2, poly);
    x8 = xtime(x4, poly);
    return x8 ^ x4 ^ v;
  endfunction

  // 0e = 8 + 4 + 2
  function automatic logic [7:0] gf_mul0e(input logic [7:0] v, input logic [7:0] poly);
    logic [7:0] x2, x4, x8;
    x2 = xtime(v, poly);
    x4 = xtime(x2, poly);
    x8 = xtime(x4, poly);
    return x8 ^ x4 ^ x2;
  endfunction

  // Inverse of xtime: an odd value had the polynomial folded in, so undo the
  // reduction first and restore the bit that was shifted out of the top.
  function automatic logic [7:0] inv_rcon(input logic [7:0] r, input logic [7:0] poly);
    logic [7:0] t;
    t = r ^ poly;
    return r[0] ? ({1'b0, t[7:1]} | 8'h80) : {1'b0, r[7:1]};
  endfunction

endpackage

// File: rtl/inv_mix_columns_seq_single_column.sv
// -----------------------------------------------------------------------------
// inv_mix_single_column
// Purely combinational InvMixColumns transform of one 32-bit column.
//   col_i [31:0] : column (a0 = [31:24], a1, a2, a3 = [7:0])
//   col_o [31:0] : transformed column, same byte order
// -----------------------------------------------------------------------------
module inv_mix_single_column
  import inv_mix_columns_seq_pkg::*;
#(
  parameter logic [7:0] POLY = AES_POLY
) (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  // Circulant matrix rows: 0e 0b 0d 09, rotated right by one per row.
  assign b0 = gf_mul0e(a0, POLY) ^ gf_mul0b(a1, POLY) ^ gf_mul0d(a2, POLY) ^ gf_mul9(a3, POLY);
  assign b1 = gf_mul9(a0, POLY)  ^ gf_mul0e(a1, POLY) ^ gf_mul0b(a2, POLY) ^ gf_mul0d(a3, POLY);
  assign b2 = gf_mul0d(a0, POLY) ^ gf_mul9(a1, POLY)  ^ gf_mul0e(a2, POLY) ^ gf_mul0b(a3, POLY);
  assign b3 = gf_mul0b(a0, POLY) ^ gf_mul0d(a1, POLY) ^ gf_mul9(a2, POLY)  ^ gf_mul0e(a3, POLY);

  assign col_o = {b0, b1, b2, b3};

endmodule

// File: rtl/inv_mix_columns_seq.sv
// -----------------------------------------------------------------------------
// inv_mix_columns_seq
// Iterative InvMixColumns engine for the AES decryption datapath. A block is
// accepted in IDLE, COLS_PER_CYCLE columns are transformed per BUSY cycle, and
// the result is held in DONE until the downstream handshake. The round
// constant is stepped backwards alongside for the reverse key schedule.
// Ports:
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake (in_ready high only in IDLE)
//   in_state  [127:0]   : state, s0 = [127:120] ... s15 = [7:0]
//   in_rcon   [7:0]     : round constant of the current round
//   out_valid/out_ready : output handshake (out_valid high only in DONE)
//   out_state [127:0]   : InvMixColumns(in_state), same byte order
//   out_rcon  [7:0]     : in_rcon divided by x in GF(2^8)
// -----------------------------------------------------------------------------
module inv_mix_columns_seq
  import inv_mix_columns_seq_pkg::*;
#(
  parameter int         COLS_PER_CYCLE = 1,
  parameter logic [7:0] POLY           = AES_POLY
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [7:0]   in_rcon,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [7:0]   out_rcon
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_e          state_q, state_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [3:0][31:0] work_q, work_d;
  logic [7:0]      rcon_q, rcon_d;
  logic            out_valid_q, out_valid_d;

  logic [COLS_PER_CYCLE-1:0][1:0]  slot;
  logic [COLS_PER_CYCLE-1:0][31:0] col_in, col_out;
  logic [2:0]                      idx_sum;

  // Column c occupies work_q[3-c] (column 0 is the top 32 bits), and 3-c on
  // two bits is simply ~c.
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign slot[k]   = ~(col_idx_q + 2'(k));
    assign col_in[k] = work_q[slot[k]];

    inv_mix_single_column #(.POLY(POLY)) u_col (
      .col_i (col_in[k]),
      .col_o (col_out[k])
    );
  end

  // Carry out of the 2-bit column counter marks the cycle that finishes
  // column 3; the low bits wrap back to 0 on the way into DONE.
  assign idx_sum = {1'b0, col_idx_q} + 3'(COLS_PER_CYCLE);

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    work_d    = work_q;
    rcon_d    = rcon_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d    = in_state;
          rcon_d    = inv_rcon(in_rcon, POLY);
          col_idx_d = 2'd0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          work_d[slot[k]] = col_out[k];
        end
        col_idx_d = idx_sum[1:0];
        if (idx_sum[2]) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      col_idx_q   <= 2'd0;
      work_q      <= '0;
      rcon_q      <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      work_q      <= work_d;
      rcon_q      <= rcon_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_state = work_q;
  assign out_rcon  = rcon_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// -----------------------------------------------------------------------------
// tb_inv_mix_columns_seq
// Directed bench for inv_mix_columns_seq. The main instance uses one column
// per cycle; two further instances (2 and 4 columns per cycle) share the
// inputs so latency can be compared on the same vector.
// -----------------------------------------------------------------------------
module tb_inv_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_state;
  logic [7:0]   in_rcon;
  logic         rdy1, rdy2, rdy4;
  logic         ir1, ir2, ir4, ov1, ov2, ov4;
  logic [127:0] os1, os2, os4;
  logic [7:0]   or1, or2, or4;

  always #5 clk = ~clk;

  inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_state(in_state),
    .in_rcon(in_rcon), .out_valid(ov1), .out_ready(rdy1), .out_state(os1), .out_rcon(or1));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_state(in_state),
    .in_rcon(in_rcon), .out_valid(ov2), .out_ready(rdy2), .out_state(os2), .out_rcon(or2));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .in_state(in_state),
    .in_rcon(in_rcon), .out_valid(ov4), .out_ready(rdy4), .out_state(os4), .out_rcon(or4));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [127:0] K_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] K_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V_IN  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] V_OUT = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Forward MixColumns reference, used to build inputs whose inverse is known.
  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] mixstate(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mixcol(s[127-32*c -: 32]);
    return r;
  endfunction

  // Bounded wait (sampled on negedges) for the main instance's out_valid.
  task automatic wait_ov1(input int limit);
    int n;
    n = 0;
    while (!ov1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("ov1_timeout", {127'd0, ov1}, 128'd1);
  endtask

  // Full block through the main instance; starts and ends on a negedge in IDLE.
  task automatic one_block(input logic [127:0] st, input logic [7:0] rc,
                           output logic [127:0] so, output logic [7:0] ro);
    in_state = st;
    in_rcon  = rc;
    in_valid = 1'b1;
    rdy1     = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_ov1(20);
    so = os1;
    ro = or1;
    @(negedge clk);
  endtask

  logic [7:0]   fwd [11] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36, 8'h00};
  logic [7:0]   bwd [11] = '{8'h8d, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h00};
  logic [127:0] xs  [8];

  initial begin
    logic [127:0] so, x;
    logic [7:0]   ro;
    int lat1, lat2, lat4, tprev, tnow;

    // Reset state
    rst = 1'b1; in_valid = 1'b0; in_state = '0; in_rcon = 8'h00;
    rdy1 = 1'b0; rdy2 = 1'b0; rdy4 = 1'b0;
    #12;
    chk("rst_in_ready", {127'd0, ir1}, 128'd1);
    chk("rst_out_valid", {127'd0, ov1}, 128'd0);
    chk("rst_out_state", os1, 128'd0);
    chk("rst_out_rcon", {120'd0, or1}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Known vector on all three widths, with latency measured from the accept edge
    in_state = K_IN; in_rcon = 8'h36; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat1 = 0; lat2 = 0; lat4 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ov1 && lat1 == 0) lat1 = k;
      if (ov2 && lat2 == 0) lat2 = k;
      if (ov4 && lat4 == 0) lat4 = k;
    end
    chk("lat_c1", 128'(lat1), 128'd4);
    chk("lat_c2", 128'(lat2), 128'd2);
    chk("lat_c4", 128'(lat4), 128'd1);
    chk("known_c1", os1, K_OUT);
    chk("known_c2", os2, K_OUT);
    chk("known_c4", os4, K_OUT);
    chk("known_rcon", {120'd0, or1}, {120'd0, 8'h1b});
    chk("known_rcon_c4", {120'd0, or4}, {120'd0, 8'h1b});
    rdy1 = 1'b1; rdy2 = 1'b1; rdy4 = 1'b1;
    @(negedge clk);
    chk("after_hs_in_ready", {127'd0, ir1}, 128'd1);
    chk("after_hs_out_valid", {127'd0, ov1}, 128'd0);

    // Second vector
    one_block(V_IN, 8'h01, so, ro);
    chk("vec2_state", so, V_OUT);
    chk("vec2_rcon", {120'd0, ro}, {120'd0, 8'h8d});

    // Backpressure: result must hold while inputs churn
    in_state = K_IN; in_rcon = 8'h36; in_valid = 1'b1; rdy1 = 1'b0;
    @(negedge clk);
    wait_ov1(20);
    for (int k = 0; k < 10; k++) begin
      in_state = {$urandom, $urandom, $urandom, $urandom};
      in_rcon  = 8'($urandom);
      @(negedge clk);
      chk("bp_state", os1, K_OUT);
      chk("bp_rcon", {120'd0, or1}, {120'd0, 8'h1b});
      chk("bp_in_ready", {127'd0, ir1}, 128'd0);
      chk("bp_out_valid", {127'd0, ov1}, 128'd1);
    end
    rdy1 = 1'b1;
    chk("bp_release_state", os1, K_OUT);
    @(negedge clk);
    chk("bp_hs_out_valid", {127'd0, ov1}, 128'd0);
    chk("bp_hs_in_ready", {127'd0, ir1}, 128'd1);
    in_valid = 1'b0;
    @(negedge clk);

    // Reset mid-BUSY, then a clean block
    in_state = V_IN; in_rcon = 8'h01; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {127'd0, ov1}, 128'd0);
    chk("midrst_out_state", os1, 128'd0);
    chk("midrst_out_rcon", {120'd0, or1}, 128'd0);
    chk("midrst_in_ready", {127'd0, ir1}, 128'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    one_block(K_IN, 8'h36, so, ro);
    chk("post_rst_state", so, K_OUT);
    chk("post_rst_rcon", {120'd0, ro}, {120'd0, 8'h1b});

    // Back-to-back random blocks: InvMix(Mix(x)) == x, period 6 cycles
    for (int i = 0; i < 8; i++) xs[i] = {$urandom, $urandom, $urandom, $urandom};
    rdy1 = 1'b1; in_valid = 1'b1; tprev = 0;
    for (int i = 0; i < 8; i++) begin
      in_state = mixstate(xs[i]);
      in_rcon  = 8'h02;
      @(negedge clk);
      wait_ov1(20);
      tnow = cyc;
      chk("b2b_state", os1, xs[i]);
      if (i > 0) chk("b2b_period", 128'(tnow - tprev), 128'd6);
      tprev = tnow;
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Rcon sweep backwards through the forward constants (plus zero)
    for (int i = 0; i < 11; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      one_block(mixstate(x), fwd[i], so, ro);
      chk("rcon_sweep", {120'd0, ro}, {120'd0, bwd[i]});
      chk("rcon_sweep_state", so, x);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
